// File: rtl/alu_wb_stage.sv
// Execute-to-writeback stage: 2-entry in-order result buffer with valid/ready
// handshakes, architectural PSR fed back to the ALU, and a back-pressure counter.
module alu_wb_stage #(
    parameter int DATA_WIDTH      = 16,
    parameter int APSR_WIDTH      = 3,
    parameter int REG_ADDR_WIDTH  = 3,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [DATA_WIDTH-1:0]      result_i,
    input  logic [APSR_WIDTH-1:0]      apsr_i,
    input  logic [REG_ADDR_WIDTH-1:0]  rd_i,
    input  logic                       wr_en_i,
    input  logic                       flags_en_i,
    input  logic                       flush_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [DATA_WIDTH-1:0]      result_o,
    output logic [REG_ADDR_WIDTH-1:0]  rd_o,
    output logic                       wr_en_o,
    output logic [APSR_WIDTH-1:0]      psr_o,
    output logic                       fwd_valid_o,
    output logic [REG_ADDR_WIDTH-1:0]  fwd_rd_o,
    output logic [DATA_WIDTH-1:0]      fwd_data_o,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o
);

    localparam logic [STALL_CNT_WIDTH-1:0] STALL_MAX = {STALL_CNT_WIDTH{1'b1}};
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE = {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]                 count_r;
    logic [DATA_WIDTH-1:0]      head_res_r;
    logic [REG_ADDR_WIDTH-1:0]  head_rd_r;
    logic                       head_wr_r;
    logic [DATA_WIDTH-1:0]      tail_res_r;
    logic [REG_ADDR_WIDTH-1:0]  tail_rd_r;
    logic                       tail_wr_r;
    logic [APSR_WIDTH-1:0]      psr_r;
    logic [STALL_CNT_WIDTH-1:0] stall_r;

    logic ready_s;
    logic valid_s;
    logic push_s;
    logic pop_s;

    // Handshake decode; ready/valid depend only on the registered count.
    always_comb begin
        ready_s = (count_r != 2'd2);
        valid_s = (count_r != 2'd0);
        push_s  = valid_i & ready_s & ~flush_i;
        pop_s   = valid_s & ready_i & ~flush_i;
    end

    // Buffer storage: head is the oldest entry, tail only used when two are held.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_r    <= 2'd0;
            head_res_r <= {DATA_WIDTH{1'b0}};
            head_rd_r  <= {REG_ADDR_WIDTH{1'b0}};
            head_wr_r  <= 1'b0;
            tail_res_r <= {DATA_WIDTH{1'b0}};
            tail_rd_r  <= {REG_ADDR_WIDTH{1'b0}};
            tail_wr_r  <= 1'b0;
        end else if (flush_i) begin
            count_r <= 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    count_r <= count_r + 2'd1;
                    if (count_r == 2'd0) begin
                        head_res_r <= result_i;
                        head_rd_r  <= rd_i;
                        head_wr_r  <= wr_en_i;
                    end else begin
                        tail_res_r <= result_i;
                        tail_rd_r  <= rd_i;
                        tail_wr_r  <= wr_en_i;
                    end
                end
                2'b01: begin
                    count_r    <= count_r - 2'd1;
                    head_res_r <= tail_res_r;
                    head_rd_r  <= tail_rd_r;
                    head_wr_r  <= tail_wr_r;
                end
                // Push and pop together only happens at count 1: new entry replaces head.
                2'b11: begin
                    count_r    <= count_r;
                    head_res_r <= result_i;
                    head_rd_r  <= rd_i;
                    head_wr_r  <= wr_en_i;
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    // PSR updates at acceptance time and is never rolled back by a flush.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            psr_r <= {APSR_WIDTH{1'b0}};
        end else if (push_s && flags_en_i) begin
            psr_r <= apsr_i;
        end else begin
            psr_r <= psr_r;
        end
    end

    // Saturating count of cycles where the head entry is back-pressured.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stall_r <= {STALL_CNT_WIDTH{1'b0}};
        end else if (valid_s && !ready_i && !flush_i && (stall_r != STALL_MAX)) begin
            stall_r <= stall_r + STALL_ONE;
        end else begin
            stall_r <= stall_r;
        end
    end

    assign ready_o     = ready_s;
    assign valid_o     = valid_s;
    assign result_o    = head_res_r;
    assign rd_o        = head_rd_r;
    assign wr_en_o     = head_wr_r;
    assign psr_o       = psr_r;
    assign fwd_valid_o = valid_s & head_wr_r;
    assign fwd_rd_o    = head_rd_r;
    assign fwd_data_o  = head_res_r;
    assign stall_cnt_o = stall_r;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Bench for alu_wb_stage: directed vector table, hand sequences for multi-cycle
// corners, and random traffic against a queue-based reference model.
module tb_alu_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n, valid, wr_en, flags_en, flush, rdy;
    logic [15:0] res;
    logic [2:0]  apsr, rd;

    logic        ready_o, valid_o, wr_en_o, fwd_valid_o;
    logic [15:0] result_o, fwd_data_o, stall_cnt_o;
    logic [2:0]  rd_o, psr_o, fwd_rd_o;

    int total = 0;
    int bad   = 0;

    alu_wb_stage dut (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .ready_o(ready_o),
        .result_i(res), .apsr_i(apsr), .rd_i(rd), .wr_en_i(wr_en),
        .flags_en_i(flags_en), .flush_i(flush), .valid_o(valid_o),
        .ready_i(rdy), .result_o(result_o), .rd_o(rd_o), .wr_en_o(wr_en_o),
        .psr_o(psr_o), .fwd_valid_o(fwd_valid_o), .fwd_rd_o(fwd_rd_o),
        .fwd_data_o(fwd_data_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [2:0]  rd;
        logic        wr;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] out_log[$];
    logic [2:0]  m_psr = 3'd0;
    int          m_stall = 0;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", n, a, e);
        end
    endfunction

    // Reference model: a FIFO queue of pending entries evaluated at each edge.
    task automatic model_update();
        ent_t e;
        int   sz;
        sz = mq.size();
        if (!rst_n) begin
            mq.delete();
            m_psr   = 3'd0;
            m_stall = 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (sz > 0 && !rdy && m_stall < 65535) m_stall++;
            if (sz > 0 && rdy) begin
                out_log.push_back(mq[0].res);
                void'(mq.pop_front());
            end
            if (valid && sz < 2) begin
                e.res = res; e.rd = rd; e.wr = wr_en;
                mq.push_back(e);
                if (flags_en) m_psr = apsr;
            end
        end
    endtask

    task automatic model_check();
        chk("valid_o", valid_o, mq.size() != 0);
        chk("ready_o", ready_o, mq.size() != 2);
        chk("psr_o", psr_o, m_psr);
        chk("stall_cnt_o", stall_cnt_o, m_stall);
        if (mq.size() != 0) begin
            chk("result_o", result_o, mq[0].res);
            chk("rd_o", rd_o, mq[0].rd);
            chk("wr_en_o", wr_en_o, mq[0].wr);
            chk("fwd_valid_o", fwd_valid_o, mq[0].wr);
            chk("fwd_rd_o", fwd_rd_o, mq[0].rd);
            chk("fwd_data_o", fwd_data_o, mq[0].res);
        end else begin
            chk("fwd_valid_idle", fwd_valid_o, 1'b0);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] r, input logic [2:0] d,
                        input logic w, input logic fe, input logic [2:0] a,
                        input logic fl, input logic rr, input logic rn);
        valid = v; res = r; rd = d; wr_en = w; flags_en = fe; apsr = a;
        flush = fl; rdy = rr; rst_n = rn;
        @(posedge clk);
        model_update();
        #1;
        model_check();
    endtask

    task automatic do_reset();
        step(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic        v;
        logic [15:0] r;
        logic [2:0]  d;
        logic        w, fe;
        logic [2:0]  a;
        logic        fl, rr, rn;
        logic        e_valid, e_ready, e_chkres;
        logic [15:0] e_res;
        logic [2:0]  e_psr;
        logic [15:0] e_stall;
    } vec_t;

    vec_t tbl[9];

    initial begin
        valid = 1'b0; res = 16'h0; rd = 3'd0; wr_en = 1'b0; flags_en = 1'b0;
        apsr = 3'd0; flush = 1'b0; rdy = 1'b0; rst_n = 1'b0;

        //        v     r         d     w     fe    a       fl    rr    rn    ev    er    ec    eres      epsr    estall
        tbl[0] = '{1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 3'b000, 16'd0};
        tbl[1] = '{1'b1, 16'h1234, 3'd3, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 3'b000, 16'd0};
        tbl[2] = '{1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 3'b000, 16'd0};
        tbl[3] = '{1'b1, 16'h0011, 3'd1, 1'b1, 1'b1, 3'b001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0011, 3'b001, 16'd0};
        tbl[4] = '{1'b1, 16'h0022, 3'd2, 1'b0, 1'b0, 3'b110, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0022, 3'b001, 16'd0};
        tbl[5] = '{1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 3'b001, 16'd0};
        tbl[6] = '{1'b1, 16'h0033, 3'd5, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0033, 3'b001, 16'd0};
        tbl[7] = '{1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0033, 3'b001, 16'd1};
        tbl[8] = '{1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 3'b001, 16'd1};

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].w, tbl[i].fe, tbl[i].a,
                 tbl[i].fl, tbl[i].rr, tbl[i].rn);
            chk($sformatf("tbl%0d_valid", i), valid_o, tbl[i].e_valid);
            chk($sformatf("tbl%0d_ready", i), ready_o, tbl[i].e_ready);
            chk($sformatf("tbl%0d_psr", i), psr_o, tbl[i].e_psr);
            chk($sformatf("tbl%0d_stall", i), stall_cnt_o, tbl[i].e_stall);
            if (tbl[i].e_chkres) chk($sformatf("tbl%0d_res", i), result_o, tbl[i].e_res);
        end

        // Back-pressure: A, B fill the buffer, C waits at the input.
        do_reset();
        out_log.delete();
        step(1'b1, 16'h0001, 3'd1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h0002, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("bp_full_ready", ready_o, 1'b0);
        step(1'b1, 16'h0003, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h0003, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 16'h0003, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        chk("bp_out_count", out_log.size(), 3);
        if (out_log.size() == 3) begin
            chk("bp_out_a", out_log[0], 16'h0001);
            chk("bp_out_b", out_log[1], 16'h0002);
            chk("bp_out_c", out_log[2], 16'h0003);
        end
        chk("bp_stall", stall_cnt_o, 16'd2);

        // Flush with the buffer full: flushed input must not push or touch PSR.
        do_reset();
        out_log.delete();
        step(1'b1, 16'h00A1, 3'd1, 1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h00A2, 3'd2, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h00A3, 3'd3, 1'b1, 1'b1, 3'b111, 1'b1, 1'b1, 1'b1);
        chk("fl_valid", valid_o, 1'b0);
        chk("fl_ready", ready_o, 1'b1);
        chk("fl_psr", psr_o, 3'b010);
        step(1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        chk("fl_no_output", out_log.size(), 0);

        // Streaming: one entry per cycle with ready held high.
        do_reset();
        out_log.delete();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 16'h0100 + 16'(i), 3'(i), 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
            chk("st_valid", valid_o, 1'b1);
            chk("st_head", result_o, 16'h0100 + 16'(i));
        end
        step(1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        chk("st_out_count", out_log.size(), 8);

        // Reset while full with a nonzero stall count.
        step(1'b1, 16'h0B01, 3'd1, 1'b1, 1'b1, 3'b101, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h0B02, 3'd2, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("pre_rst_stall", stall_cnt_o, 16'd2);
        do_reset();
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_result", result_o, 16'h0);
        chk("rst_rd", rd_o, 3'd0);
        chk("rst_wr_en", wr_en_o, 1'b0);
        chk("rst_fwd_valid", fwd_valid_o, 1'b0);
        chk("rst_psr", psr_o, 3'd0);
        chk("rst_stall", stall_cnt_o, 16'd0);

        // Saturation of the stall counter.
        step(1'b1, 16'h0C01, 3'd1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 65541; i++)
            step(1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("stall_sat", stall_cnt_o, 16'hFFFF);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), 3'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 3'($urandom), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
